// File: rtl/memory_access_unit.sv
// Memory access unit: issues a single load or store to a request/acknowledge
// memory port, with a bounded wait and a one-cycle completion or error pulse.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | waiting for start; access fields latched on acceptance
//   REQ   | mem_req asserted, waiting for mem_ack or the wait limit
//   DONE  | single completion cycle: done pulse, data_valid for loads
module memory_access_unit #(
   parameter int BITS_DATA = 32,
   parameter int BITS_ADDR = 16,
   parameter int TIMEOUT   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 write_en,
   input  logic [BITS_ADDR-1:0] addr_in,
   input  logic [BITS_DATA-1:0] data_in,
   output logic [BITS_ADDR-1:0] mem_addr,
   output logic [BITS_DATA-1:0] mem_wdata,
   output logic                 mem_req,
   output logic                 mem_we,
   input  logic                 mem_ack,
   input  logic [BITS_DATA-1:0] mem_rdata,
   output logic [BITS_DATA-1:0] data_out,
   output logic                 data_valid,
   output logic                 done,
   output logic                 busy,
   output logic                 error
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   // The wait counter is 4 bits wide, so the limit is truncated to match.
   localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] wait_cnt;
   logic [3:0] wait_cnt_nxt;
   logic       accept;
   logic       capture;
   logic       timeout_hit;

   // State and wait-counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Next-state decode; an ack arriving in the final wait cycle beats the timeout.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      accept       = 1'b0;
      capture      = 1'b0;
      timeout_hit  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept       = 1'b1;
               wait_cnt_nxt = 4'd0;
               state_nxt    = REQ;
            end
         end
         REQ: begin
            if (mem_ack) begin
               capture   = ~mem_we;
               state_nxt = DONE;
            end else begin
               wait_cnt_nxt = wait_cnt + 4'd1;
               if (wait_cnt + 4'd1 == TIMEOUT_CNT) begin
                  timeout_hit = 1'b1;
                  state_nxt   = IDLE;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Registered outputs, derived from the state being entered so they line up with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_we     <= 1'b0;
         mem_req    <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
         error      <= 1'b0;
      end else begin
         if (accept) begin
            mem_addr  <= addr_in;
            mem_wdata <= data_in;
            mem_we    <= write_en;
         end
         if (capture) begin
            data_out <= mem_rdata;
         end
         mem_req    <= (state_nxt == REQ);
         busy       <= (state_nxt != IDLE);
         done       <= (state_nxt == DONE);
         data_valid <= (state_nxt == DONE) && !mem_we;
         error      <= timeout_hit;
      end
   end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 Parameter BITS_DATA SHALL be: default 32; data word width.
REQ-002 Parameter BITS_ADDR SHALL be: default 16; address width.
REQ-003 Parameter TIMEOUT SHALL be: default 8, legal range 1..15; maximum number of mem_req cycles before abort.
REQ-004 Port clk SHALL be: input, 1 bit; single clock, all state updates on its rising edge.
REQ-005 Port reset SHALL be: input, 1 bit; synchronous, active-high.
REQ-006 Port start SHALL be: input, 1 bit; access request from control, sampled only in IDLE.
REQ-007 Port write_en SHALL be: input, 1 bit; 1 = store, 0 = load; sampled with start.
REQ-008 Port addr_in SHALL be: input, BITS_ADDR; access address; sampled with start.
REQ-009 Port data_in SHALL be: input, BITS_DATA; store data; sampled with start.
REQ-010 Port mem_addr SHALL be: output, BITS_ADDR; registered address to memory.
REQ-011 Port mem_wdata SHALL be: output, BITS_DATA; registered store data to memory.
REQ-012 Port mem_req SHALL be: output, 1 bit; request to memory, high only in REQ.
REQ-013 Port mem_we SHALL be: output, 1 bit; latched write_en.
REQ-014 Port mem_ack SHALL be: input, 1 bit; memory completion.
REQ-015 Port mem_rdata SHALL be: input, BITS_DATA; load data, valid in the mem_ack cycle.
REQ-016 Port data_out SHALL be: output, BITS_DATA; captured load word feeding the memory data register.
REQ-017 Port data_valid SHALL be: output, 1 bit; one-cycle pulse, data_out newly captured.
REQ-018 Port done SHALL be: output, 1 bit; one-cycle pulse on successful completion of a load or store.
REQ-019 Port busy SHALL be: output, 1 bit; high whenever state is not IDLE.
REQ-020 Port error SHALL be: output, 1 bit; one-cycle pulse on timeout.

Function
REQ-021 FSM states SHALL be IDLE, REQ, DONE; all outputs SHALL be registered.
REQ-022 In IDLE with start=1: latch addr_in, data_in and write_en into mem_addr, mem_wdata and mem_we; clear wait counter; go to REQ.
REQ-023 In REQ: mem_req=1; if mem_ack=1, then for loads capture mem_rdata into data_out, and go to DONE.
REQ-024 In REQ with mem_ack=0: increment the 4-bit wait counter; if the counter reaches TIMEOUT, go to IDLE, pulse error for one cycle, and leave data_out unchanged.
REQ-025 mem_ack in the same cycle the counter would reach TIMEOUT: ack SHALL win (normal completion, no error).
REQ-026 DONE SHALL last exactly one cycle: done=1; data_valid=1 for loads only; then return to IDLE.
REQ-027 start in REQ or DONE SHALL be ignored (not queued); mem_addr, mem_wdata and mem_we SHALL stay stable throughout REQ.
REQ-028 mem_ack in IDLE or DONE SHALL be ignored.
REQ-029 Latency: start sampled at edge n -> mem_req high from edge n; mem_ack sampled at edge k -> done/data_valid high for the cycle after edge k; minimum start-to-done is 2 cycles.
REQ-030 A store SHALL never modify data_out.
REQ-031 Back-to-back accesses: start asserted in the IDLE cycle following DONE SHALL be accepted.

Reset
REQ-032 reset=1 at a clock edge SHALL force IDLE from any state, including mid-REQ, with no error pulse.
REQ-033 Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, data_out=0, data_valid=0, done=0, busy=0, error=0, wait counter=0.
REQ-034 reset SHALL take priority over start and mem_ack in the same cycle.

Verification (TIMEOUT=4)
REQ-035 Load: start, write_en=0, addr_in=0x0010; mem_ack=1 with mem_rdata=0xDEADBEEF on the 3rd REQ cycle -> mem_addr=0x0010; data_out=0xDEADBEEF; data_valid and done high for 1 cycle; busy low afterwards.
REQ-036 Store: start, write_en=1, addr_in=0x0004, data_in=0x12345678; mem_ack on the 1st REQ cycle -> mem_we=1, mem_wdata=0x12345678, done pulse, data_valid=0, data_out unchanged.
REQ-037 Timeout: start load with mem_ack held 0 -> mem_req high 4 cycles, then error pulse for 1 cycle, IDLE, data_out unchanged; ack on the 4th cycle instead -> done, no error.
REQ-038 Reset mid-REQ: reset on the 2nd REQ cycle -> next cycle mem_req=0, busy=0, all outputs at reset values, no error.
REQ-039 Ignored start: start pulsed with addr_in=0x0099 during REQ of an access to 0x0010 -> mem_addr stays 0x0010; only one done pulse; no second access.
REQ-040 Back-to-back: load (rdata 0x1) then start on the next IDLE cycle for a load (rdata 0x2) -> two data_valid pulses with data_out 0x1 then 0x2.
